kronos_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage and upstream of write-back. It accepts one memory request at a time, performs a sized, aligned access on a simple req/ack data bus, and hands the result to write-back. Sub-word data is aligned and extended for loads and replicated and masked for stores. Misaligned accesses are trapped with the machine exception codes LOAD_ADDR_MISALIGNED=4 and STORE_ADDR_MISALIGNED=6.

---
 rtl/kronos_lsu_if.sv | 48 ++++
 rtl/kronos_lsu.sv | 184 ++++++++++++++++++
 tb/tb_kronos_lsu.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/kronos_lsu_if.sv
// Bundle of the LSU's execute-side request, data-bus and write-back signals.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface kronos_lsu_if;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_load;
    logic        lsu_store;
    logic [1:0]  lsu_size;
    logic        lsu_uns;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [4:0]  lsu_rd;

    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rd_data;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_regwr;
    logic        wb_exc;
    logic [3:0]  wb_cause;
    logic [31:0] wb_tval;

    modport slave (
        input  lsu_valid, lsu_load, lsu_store, lsu_size, lsu_uns, lsu_addr, lsu_wdata, lsu_rd,
        output lsu_ready,
        output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
        input  data_ack, data_rd_data,
        output wb_valid, wb_rd, wb_data, wb_regwr, wb_exc, wb_cause, wb_tval,
        input  wb_ready
    );

    modport master (
        output lsu_valid, lsu_load, lsu_store, lsu_size, lsu_uns, lsu_addr, lsu_wdata, lsu_rd,
        input  lsu_ready,
        input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
        output data_ack, data_rd_data,
        input  wb_valid, wb_rd, wb_data, wb_regwr, wb_exc, wb_cause, wb_tval,
        output wb_ready
    );
endinterface

// File: rtl/kronos_lsu.sv
// RV32 load/store unit: one sized, aligned access at a time on a req/ack bus,
// with misalignment traps and load extension before handing off to write-back.
module kronos_lsu (
    input  logic              clk,
    input  logic              rstz,
    kronos_lsu_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t      state_q, state_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wr_data_q, data_wr_data_d;
    logic [3:0]  data_mask_q, data_mask_d;
    logic        data_wr_en_q, data_wr_en_d;
    logic        data_req_q, data_req_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_regwr_q, wb_regwr_d;
    logic        wb_exc_q, wb_exc_d;
    logic [3:0]  wb_cause_q, wb_cause_d;
    logic [31:0] wb_tval_q, wb_tval_d;
    // Access attributes kept for aligning/extending the read data at ack time
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        is_load_q, is_load_d;

    logic        is_st, is_ld, sz_byte, sz_half, misaligned;
    logic [31:0] shifted, load_ext;

    always_comb begin
        is_st      = bus.lsu_store;
        is_ld      = bus.lsu_load & ~bus.lsu_store;
        sz_byte    = (bus.lsu_size == SZ_BYTE);
        sz_half    = (bus.lsu_size == SZ_HALF);
        misaligned = (sz_half & bus.lsu_addr[0]) |
                     (~sz_byte & ~sz_half & (bus.lsu_addr[1:0] != 2'b00));

        shifted = bus.data_rd_data >> {off_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        data_addr_d    = data_addr_q;
        data_wr_data_d = data_wr_data_q;
        data_mask_d    = data_mask_q;
        data_wr_en_d   = data_wr_en_q;
        data_req_d     = data_req_q;
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_regwr_d     = wb_regwr_q;
        wb_exc_d       = wb_exc_q;
        wb_cause_d     = wb_cause_q;
        wb_tval_d      = wb_tval_q;
        size_d         = size_q;
        off_d          = off_q;
        uns_d          = uns_q;
        is_load_d      = is_load_q;

        case (state_q)
            IDLE: begin
                if (bus.lsu_valid) begin
                    wb_rd_d    = bus.lsu_rd;
                    wb_data_d  = '0;
                    wb_regwr_d = 1'b0;
                    wb_exc_d   = 1'b0;
                    wb_cause_d = '0;
                    wb_tval_d  = '0;
                    if (!is_ld && !is_st) begin
                        wb_valid_d = 1'b1;
                        state_d    = DONE;
                    end else if (misaligned) begin
                        wb_exc_d   = 1'b1;
                        wb_cause_d = is_st ? 4'd6 : 4'd4;
                        wb_tval_d  = bus.lsu_addr;
                        wb_valid_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        data_addr_d  = {bus.lsu_addr[31:2], 2'b00};
                        data_wr_en_d = is_st;
                        data_req_d   = 1'b1;
                        if (sz_byte) begin
                            data_wr_data_d = {4{bus.lsu_wdata[7:0]}};
                            data_mask_d    = 4'b0001 << bus.lsu_addr[1:0];
                        end else if (sz_half) begin
                            data_wr_data_d = {2{bus.lsu_wdata[15:0]}};
                            data_mask_d    = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
                        end else begin
                            data_wr_data_d = bus.lsu_wdata;
                            data_mask_d    = 4'b1111;
                        end
                        size_d    = bus.lsu_size;
                        off_d     = bus.lsu_addr[1:0];
                        uns_d     = bus.lsu_uns;
                        is_load_d = is_ld;
                        state_d   = BUS;
                    end
                end
            end
            BUS: begin
                if (bus.data_ack) begin
                    data_req_d = 1'b0;
                    if (is_load_q) begin
                        wb_data_d  = load_ext;
                        wb_regwr_d = (wb_rd_q != 5'd0);
                    end
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q        <= IDLE;
            data_addr_q    <= '0;
            data_wr_data_q <= '0;
            data_mask_q    <= '0;
            data_wr_en_q   <= 1'b0;
            data_req_q     <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_regwr_q     <= 1'b0;
            wb_exc_q       <= 1'b0;
            wb_cause_q     <= '0;
            wb_tval_q      <= '0;
            size_q         <= '0;
            off_q          <= '0;
            uns_q          <= 1'b0;
            is_load_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_addr_q    <= data_addr_d;
            data_wr_data_q <= data_wr_data_d;
            data_mask_q    <= data_mask_d;
            data_wr_en_q   <= data_wr_en_d;
            data_req_q     <= data_req_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_regwr_q     <= wb_regwr_d;
            wb_exc_q       <= wb_exc_d;
            wb_cause_q     <= wb_cause_d;
            wb_tval_q      <= wb_tval_d;
            size_q         <= size_d;
            off_q          <= off_d;
            uns_q          <= uns_d;
            is_load_q      <= is_load_d;
        end
    end

    assign bus.lsu_ready    = (state_q == IDLE);
    assign bus.data_addr    = data_addr_q;
    assign bus.data_wr_data = data_wr_data_q;
    assign bus.data_mask    = data_mask_q;
    assign bus.data_wr_en   = data_wr_en_q;
    assign bus.data_req     = data_req_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_regwr     = wb_regwr_q;
    assign bus.wb_exc       = wb_exc_q;
    assign bus.wb_cause     = wb_cause_q;
    assign bus.wb_tval      = wb_tval_q;
endmodule

// File: tb/tb_kronos_lsu.sv
// Directed bench for kronos_lsu: loads, stores, traps, write-back stall and mid-access reset.
module tb_kronos_lsu;
    logic clk = 1'b0;
    logic rstz;
    int unsigned checks = 0;
    int unsigned errors = 0;

    kronos_lsu_if bus ();

    kronos_lsu u_dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle; call at a negedge with the LSU idle.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        check("ready_before_issue", 32'(bus.lsu_ready), 32'd1);
        bus.lsu_valid = 1'b1;
        bus.lsu_load  = ld;
        bus.lsu_store = st;
        bus.lsu_size  = sz;
        bus.lsu_uns   = uns;
        bus.lsu_addr  = addr;
        bus.lsu_wdata = wdata;
        bus.lsu_rd    = rd;
        @(negedge clk);
        bus.lsu_valid = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] d);
        bus.data_ack     = 1'b1;
        bus.data_rd_data = d;
        @(negedge clk);
        bus.data_ack     = 1'b0;
        bus.data_rd_data = 32'h0;
        check("req_dropped", 32'(bus.data_req), 32'd0);
        check("wb_valid_after_ack", 32'(bus.wb_valid), 32'd1);
    endtask

    task automatic wb_take;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        check("wb_valid_cleared", 32'(bus.wb_valid), 32'd0);
        check("ready_after_wb", 32'(bus.lsu_ready), 32'd1);
    endtask

    // Aligned load with immediate ack; checks mask and final write-back result.
    task automatic load_case(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rdata, input logic [4:0] rd,
                             input logic [3:0] exp_mask, input logic [31:0] exp_data,
                             input logic exp_regwr);
        issue(1'b1, 1'b0, sz, uns, addr, 32'h0, rd);
        check({tag, "_mask"}, 32'(bus.data_mask), 32'(exp_mask));
        check({tag, "_wren"}, 32'(bus.data_wr_en), 32'd0);
        ack_with(rdata);
        check({tag, "_data"}, bus.wb_data, exp_data);
        check({tag, "_regwr"}, 32'(bus.wb_regwr), 32'(exp_regwr));
        check({tag, "_exc"}, 32'(bus.wb_exc), 32'd0);
        wb_take();
    endtask

    initial begin
        rstz = 1'b0;
        bus.lsu_valid = 1'b0; bus.lsu_load = 1'b0; bus.lsu_store = 1'b0;
        bus.lsu_size = 2'b00; bus.lsu_uns = 1'b0; bus.lsu_addr = 32'h0;
        bus.lsu_wdata = 32'h0; bus.lsu_rd = 5'd0;
        bus.data_ack = 1'b0; bus.data_rd_data = 32'h0; bus.wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.data_req), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_addr", bus.data_addr, 32'h0);
        check("rst_mask", 32'(bus.data_mask), 32'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_ready", 32'(bus.lsu_ready), 32'd1);
        rstz = 1'b1;
        @(negedge clk);

        // LW 0x100 with three wait cycles
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
        for (int i = 0; i < 3; i++) begin
            check("lw_req_held", 32'(bus.data_req), 32'd1);
            check("lw_addr", bus.data_addr, 32'h100);
            check("lw_mask", 32'(bus.data_mask), 32'hF);
            check("lw_busy", 32'(bus.lsu_ready), 32'd0);
            @(negedge clk);
        end
        ack_with(32'hDEADBEEF);
        check("lw_data", bus.wb_data, 32'hDEADBEEF);
        check("lw_regwr", 32'(bus.wb_regwr), 32'd1);
        check("lw_rd", 32'(bus.wb_rd), 32'd5);
        wb_take();

        load_case("lb",  2'b00, 1'b0, 32'h203, 32'h80112233, 5'd7, 4'b1000, 32'hFFFFFF80, 1'b1);
        load_case("lbu", 2'b00, 1'b1, 32'h203, 32'h80112233, 5'd7, 4'b1000, 32'h00000080, 1'b1);
        load_case("lh",  2'b01, 1'b0, 32'h202, 32'h80112233, 5'd9, 4'b1100, 32'hFFFF8011, 1'b1);
        load_case("lbu1", 2'b00, 1'b1, 32'h201, 32'h80112233, 5'd3, 4'b0010, 32'h00000022, 1'b1);
        load_case("lw_x0", 2'b10, 1'b0, 32'h40, 32'h12345678, 5'd0, 4'b1111, 32'h12345678, 1'b0);

        // SH 0x302
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD, 5'd4);
        check("sh_addr", bus.data_addr, 32'h300);
        check("sh_wdata", bus.data_wr_data, 32'hABCDABCD);
        check("sh_mask", 32'(bus.data_mask), 32'hC);
        check("sh_wren", 32'(bus.data_wr_en), 32'd1);
        ack_with(32'hFFFFFFFF);
        check("sh_regwr", 32'(bus.wb_regwr), 32'd0);
        check("sh_exc", 32'(bus.wb_exc), 32'd0);
        check("sh_data", bus.wb_data, 32'h0);
        wb_take();

        // SB 0x101, with load also set: store wins
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h12345677, 5'd4);
        check("sb_wdata", bus.data_wr_data, 32'h77777777);
        check("sb_mask", 32'(bus.data_mask), 32'h2);
        check("sb_wren", 32'(bus.data_wr_en), 32'd1);
        ack_with(32'h0);
        check("sb_regwr", 32'(bus.wb_regwr), 32'd0);
        wb_take();

        // Misaligned LW 0x101
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd6);
        check("lwmis_req", 32'(bus.data_req), 32'd0);
        check("lwmis_valid", 32'(bus.wb_valid), 32'd1);
        check("lwmis_exc", 32'(bus.wb_exc), 32'd1);
        check("lwmis_cause", 32'(bus.wb_cause), 32'd4);
        check("lwmis_tval", bus.wb_tval, 32'h101);
        check("lwmis_regwr", 32'(bus.wb_regwr), 32'd0);
        wb_take();

        // Misaligned SW 0x102
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd6);
        check("swmis_req", 32'(bus.data_req), 32'd0);
        check("swmis_exc", 32'(bus.wb_exc), 32'd1);
        check("swmis_cause", 32'(bus.wb_cause), 32'd6);
        check("swmis_tval", bus.wb_tval, 32'h102);
        wb_take();

        // Misaligned LH 0x105 (size 11 aligned word case covered below)
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h105, 32'h0, 5'd6);
        check("lhmis_cause", 32'(bus.wb_cause), 32'd4);
        wb_take();

        // No-op request
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 5'd8);
        check("nop_req", 32'(bus.data_req), 32'd0);
        check("nop_valid", 32'(bus.wb_valid), 32'd1);
        check("nop_exc", 32'(bus.wb_exc), 32'd0);
        check("nop_regwr", 32'(bus.wb_regwr), 32'd0);
        wb_take();

        // Write-back stall: size 11 acts as WORD
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 5'd10);
        check("stall_mask", 32'(bus.data_mask), 32'hF);
        ack_with(32'hCAFEF00D);
        bus.lsu_valid = 1'b1; bus.lsu_load = 1'b1; bus.lsu_store = 1'b0;
        bus.lsu_size = 2'b10; bus.lsu_addr = 32'h600; bus.lsu_rd = 5'd11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.wb_valid), 32'd1);
            check("stall_data", bus.wb_data, 32'hCAFEF00D);
            check("stall_rd", 32'(bus.wb_rd), 32'd10);
            check("stall_busy", 32'(bus.lsu_ready), 32'd0);
            check("stall_no_req", 32'(bus.data_req), 32'd0);
        end
        bus.lsu_valid = 1'b0;
        wb_take();

        // Reset in the middle of a bus access; a late ack must be ignored
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd12);
        check("rstmid_req", 32'(bus.data_req), 32'd1);
        rstz = 1'b0;
        @(negedge clk);
        rstz = 1'b1;
        bus.data_ack = 1'b1; bus.data_rd_data = 32'h55555555;
        @(negedge clk);
        bus.data_ack = 1'b0;
        check("rstmid_req_low", 32'(bus.data_req), 32'd0);
        check("rstmid_no_wb", 32'(bus.wb_valid), 32'd0);
        check("rstmid_ready", 32'(bus.lsu_ready), 32'd1);
        check("rstmid_addr", bus.data_addr, 32'h0);
        @(negedge clk);
        check("rstmid_no_wb2", 32'(bus.wb_valid), 32'd0);

        load_case("post_rst", 2'b10, 1'b0, 32'h104, 32'h0BADC0DE, 5'd13, 4'b1111, 32'h0BADC0DE, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end
endmodule
